// File: rtl/spiker_result_fifo.sv
// ---------------------------------------------------------------------------
// spiker_result_fifo
//
// Result buffer between the spiking core's output vector and the register
// file. Each completed spike-result frame is captured into a DEPTH-entry FIFO
// so that back-to-back inference results survive while software is still
// reading the previous one. The head frame is exposed as N_REG words of WIDTH
// bits. A sample-window counter with sticky status flags runs alongside.
//
// Optional feature (compile-time macro):
//   SPIKER_RESULT_FIFO_OVERWRITE_EN
//     defined   : a push into a full FIFO (no pop) overwrites the oldest frame;
//                 core_ready_o is tied high.
//     undefined : a push into a full FIFO (no pop) drops the new frame.
//     overflow_o is set on such a push in both builds.
//
// Ports:
//   clk_i           in   1                 clock, rising edge
//   rst_ni          in   1                 asynchronous active-low reset
//   core_data_i     in   DATA_WIDTH        result vector, valid with core_valid_i
//   core_valid_i    in   1                 one-cycle pulse per result frame
//   core_ready_o    out  1                 FIFO can accept a frame
//   sample_i        in   1                 sample strobe from core timing
//   pop_i           in   1                 software acknowledge of head frame
//   clear_i         in   1                 synchronous flush (highest priority)
//   result_o        out  N_REG*WIDTH       head frame, zero-extended, 0 if empty
//   result_valid_o  out  1                 FIFO not empty
//   level_o         out  clog2(DEPTH+1)    number of stored frames
//   sample_count_o  out  clog2(SPS+1)      position in the sample window
//   step_done_o     out  1                 sticky: a sample window completed
//   overflow_o      out  1                 sticky: frame offered while full
// ---------------------------------------------------------------------------
module spiker_result_fifo #(
    parameter int WIDTH            = 32,
    parameter int DATA_WIDTH       = 800,
    parameter int N_REG            = 25,
    parameter int DEPTH            = 4,
    parameter int SAMPLES_PER_STEP = 15
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [DATA_WIDTH-1:0]                   core_data_i,
    input  logic                                    core_valid_i,
    output logic                                    core_ready_o,
    input  logic                                    sample_i,
    input  logic                                    pop_i,
    input  logic                                    clear_i,
    output logic [N_REG*WIDTH-1:0]                  result_o,
    output logic                                    result_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]              level_o,
    output logic [$clog2(SAMPLES_PER_STEP+1)-1:0]   sample_count_o,
    output logic                                    step_done_o,
    output logic                                    overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(SAMPLES_PER_STEP + 1);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_STEP - 1);

    // DEPTH is a power of two, so pointer wrap is the natural modulo of PTR_W.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + PTR_W'(1);
    endfunction

    // Next position in the sample window, wrapping after the last sample.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt);
        if (cnt == CNT_LAST) begin
            return '0;
        end
        return cnt + CNT_W'(1);
    endfunction

    // Registered state.
    logic [DATA_WIDTH-1:0] mem_p0 [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_p0;
    logic [PTR_W-1:0]      rd_ptr_p0;
    logic [LVL_W-1:0]      level_p0;
    logic [CNT_W-1:0]      cnt_p0;
    logic                  step_done_p0;
    logic                  overflow_p0;

    logic full;
    logic empty;
    logic vld_p0;
    logic do_push;
    logic do_pop;
    logic ovw;
    logic drop_evt;
    logic adv_rd;

    assign full   = (level_p0 == LVL_FULL);
    assign empty  = (level_p0 == '0);
    assign vld_p0 = ~empty;

    // A pop on an empty FIFO is ignored, including when paired with a push.
    assign do_pop   = pop_i & ~empty;
    // A frame offered to a full FIFO without a same-cycle pop.
    assign drop_evt = core_valid_i & full & ~pop_i;

`ifdef SPIKER_RESULT_FIFO_OVERWRITE_EN
    // Overwrite-oldest: every offered frame is written; when full, the read
    // pointer is pushed forward to discard the oldest entry.
    assign do_push      = core_valid_i;
    assign ovw          = drop_evt;
    assign core_ready_o = 1'b1;
`else
    // Drop-newest: a full FIFO only accepts when a pop frees a slot this cycle.
    assign do_push      = core_valid_i & (~full | pop_i);
    assign ovw          = 1'b0;
    assign core_ready_o = ~full;
`endif

    assign adv_rd = do_pop | ovw;

    // ---- stage p0: pointers, level and flags ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_p0    <= '0;
            rd_ptr_p0    <= '0;
            level_p0     <= '0;
            cnt_p0       <= '0;
            step_done_p0 <= 1'b0;
            overflow_p0  <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_p0    <= '0;
            rd_ptr_p0    <= '0;
            level_p0     <= '0;
            cnt_p0       <= '0;
            step_done_p0 <= 1'b0;
            overflow_p0  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_p0 <= ptr_inc(wr_ptr_p0);
            end
            if (adv_rd) begin
                rd_ptr_p0 <= ptr_inc(rd_ptr_p0);
            end
            // Overwrite keeps the level at DEPTH; push+pop keeps it as is.
            if (do_push && !do_pop && !ovw) begin
                level_p0 <= level_p0 + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level_p0 <= level_p0 - LVL_W'(1);
            end
            if (drop_evt) begin
                overflow_p0 <= 1'b1;
            end
            if (sample_i) begin
                cnt_p0 <= cnt_next(cnt_p0);
                if (cnt_p0 == CNT_LAST) begin
                    step_done_p0 <= 1'b1;
                end
            end
        end
    end

    // ---- stage p0: frame storage ----
    // clear_i only resets pointers; stale entries are unreachable afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_p0[i] <= '0;
            end
        end else if (do_push && !clear_i) begin
            mem_p0[wr_ptr_p0] <= core_data_i;
        end
    end

    // Head frame read straight from the registered read pointer.
    always_comb begin
        result_o = '0;
        if (vld_p0) begin
            result_o[DATA_WIDTH-1:0] = mem_p0[rd_ptr_p0];
        end
    end

    assign result_valid_o = vld_p0;
    assign level_o        = level_p0;
    assign sample_count_o = cnt_p0;
    assign step_done_o    = step_done_p0;
    assign overflow_o     = overflow_p0;

endmodule

// File: tb/tb_spiker_result_fifo.sv
module tb_spiker_result_fifo;

    localparam int WIDTH      = 32;
    localparam int DATA_WIDTH = 800;
    localparam int N_REG      = 25;
    localparam int DEPTH      = 4;
    localparam int SPS        = 15;
    localparam int OW         = N_REG * WIDTH;
    localparam int OW26       = 26 * WIDTH;
    localparam int LW         = $clog2(DEPTH + 1);
    localparam int CW         = $clog2(SPS + 1);

    logic                  clk;
    logic                  rst_n;
    logic [DATA_WIDTH-1:0] core_data;
    logic                  core_valid;
    logic                  sample;
    logic                  pop;
    logic                  clear;

    logic                  core_ready;
    logic [OW-1:0]         result;
    logic                  result_valid;
    logic [LW-1:0]         level;
    logic [CW-1:0]         sample_count;
    logic                  step_done;
    logic                  overflow;

    logic                  core_ready_b;
    logic [OW26-1:0]       result_b;
    logic                  result_valid_b;
    logic [LW-1:0]         level_b;
    logic [CW-1:0]         sample_count_b;
    logic                  step_done_b;
    logic                  overflow_b;

    spiker_result_fifo #(
        .WIDTH(WIDTH), .DATA_WIDTH(DATA_WIDTH), .N_REG(N_REG),
        .DEPTH(DEPTH), .SAMPLES_PER_STEP(SPS)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .core_data_i(core_data),
        .core_valid_i(core_valid), .core_ready_o(core_ready),
        .sample_i(sample), .pop_i(pop), .clear_i(clear),
        .result_o(result), .result_valid_o(result_valid), .level_o(level),
        .sample_count_o(sample_count), .step_done_o(step_done),
        .overflow_o(overflow)
    );

    // Wider readout variant: one extra word beyond the frame.
    spiker_result_fifo #(
        .WIDTH(WIDTH), .DATA_WIDTH(DATA_WIDTH), .N_REG(26),
        .DEPTH(DEPTH), .SAMPLES_PER_STEP(SPS)
    ) dut26 (
        .clk_i(clk), .rst_ni(rst_n), .core_data_i(core_data),
        .core_valid_i(core_valid), .core_ready_o(core_ready_b),
        .sample_i(sample), .pop_i(pop), .clear_i(clear),
        .result_o(result_b), .result_valid_o(result_valid_b), .level_o(level_b),
        .sample_count_o(sample_count_b), .step_done_o(step_done_b),
        .overflow_o(overflow_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard and reference state.
    logic [DATA_WIDTH-1:0] sb[$];
    logic                  m_ovf;
    logic                  m_step;
    int                    m_cnt;

    function automatic logic [DATA_WIDTH-1:0] rand_frame();
        logic [DATA_WIDTH-1:0] f;
        for (int i = 0; i < DATA_WIDTH / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    function automatic logic [OW-1:0] exp_head();
        if (sb.size() == 0) return '0;
        return OW'(sb[0]);
    endfunction

    function automatic logic exp_ready();
`ifdef SPIKER_RESULT_FIFO_OVERWRITE_EN
        return 1'b1;
`else
        return sb.size() != DEPTH;
`endif
    endfunction

    function automatic void model_reset();
        sb.delete();
        m_ovf  = 1'b0;
        m_step = 1'b0;
        m_cnt  = 0;
    endfunction

    // Drive one cycle of inputs, advance the reference model at the edge,
    // return #1 after the edge with inputs idle.
    task automatic drive(input logic v, input logic [DATA_WIDTH-1:0] d,
                         input logic p, input logic s, input logic c);
        logic [DATA_WIDTH-1:0] tmp;
        @(negedge clk);
        core_valid = v; core_data = d; pop = p; sample = s; clear = c;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            if (v && sb.size() == DEPTH && !p) begin
                m_ovf = 1'b1;
`ifdef SPIKER_RESULT_FIFO_OVERWRITE_EN
                tmp = sb.pop_front();
                sb.push_back(d);
`endif
            end else begin
                if (p && sb.size() > 0) tmp = sb.pop_front();
                if (v) sb.push_back(d);
            end
            if (s) begin
                if (m_cnt == SPS - 1) begin
                    m_cnt  = 0;
                    m_step = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
        end
        #1;
        core_valid = 1'b0; pop = 1'b0; sample = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (core_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", core_ready); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", result_valid); end
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got %0h want 0", result); end
        total++; if (sample_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", sample_count); end
        total++; if ({step_done, overflow} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {step_done, overflow}); end
    endtask

    task automatic test_fifo_order();
        logic [DATA_WIDTH-1:0] a, b, c;
        a = rand_frame(); b = rand_frame(); c = rand_frame();
        drive(1'b1, a, 1'b0, 1'b0, 1'b0);
        total++; if (result !== OW'(a)) begin bad++; $display("FAIL order_first_head: got %0h want %0h", result, a); end
        drive(1'b1, b, 1'b0, 1'b0, 1'b0);
        drive(1'b1, c, 1'b0, 1'b0, 1'b0);
        total++; if (level !== LW'(3)) begin bad++; $display("FAIL order_level3: got %0d want 3", level); end
        total++; if (result !== OW'(a)) begin bad++; $display("FAIL order_head_a: got %0h want %0h", result, a); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            total++; if (result !== exp_head()) begin bad++; $display("FAIL order_pop%0d_head: got %0h want %0h", i, result, exp_head()); end
            total++; if (result_valid !== (sb.size() != 0)) begin bad++; $display("FAIL order_pop%0d_valid: got %0b want %0b", i, result_valid, sb.size() != 0); end
        end
        total++; if (result !== '0) begin bad++; $display("FAIL order_empty_zero: got %0h want 0", result); end
    endtask

    task automatic test_overflow();
        logic [DATA_WIDTH-1:0] f [5];
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) f[i] = rand_frame();
        for (int i = 0; i < 4; i++) drive(1'b1, f[i], 1'b0, 1'b0, 1'b0);
        total++; if (level !== LW'(4)) begin bad++; $display("FAIL ovf_level_full: got %0d want 4", level); end
        total++; if (core_ready !== exp_ready()) begin bad++; $display("FAIL ovf_ready_full: got %0b want %0b", core_ready, exp_ready()); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_flag_early: got %0b want 0", overflow); end
        drive(1'b1, f[4], 1'b0, 1'b0, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
        total++; if (level !== LW'(4)) begin bad++; $display("FAIL ovf_level: got %0d want 4", level); end
`ifdef SPIKER_RESULT_FIFO_OVERWRITE_EN
        total++; if (result !== OW'(f[1])) begin bad++; $display("FAIL ovf_head: got %0h want %0h", result, f[1]); end
`else
        total++; if (result !== OW'(f[0])) begin bad++; $display("FAIL ovf_head: got %0h want %0h", result, f[0]); end
`endif
        for (int i = 0; i < 4; i++) begin
            total++; if (result !== exp_head()) begin bad++; $display("FAIL ovf_drain%0d: got %0h want %0h", i, result, exp_head()); end
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained: got %0b want 0", result_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [DATA_WIDTH-1:0] f;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, rand_frame(), 1'b0, 1'b0, 1'b0);
        f = rand_frame();
        drive(1'b1, f, 1'b1, 1'b0, 1'b0);
        total++; if (level !== LW'(4)) begin bad++; $display("FAIL fullpp_level: got %0d want 4", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpp_ovf: got %0b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            total++; if (result !== exp_head()) begin bad++; $display("FAIL fullpp_drain%0d: got %0h want %0h", i, result, exp_head()); end
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_pop_empty();
        logic [DATA_WIDTH-1:0] f;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        total++; if (level !== '0) begin bad++; $display("FAIL popempty_level: got %0d want 0", level); end
        total++; if ({overflow, result_valid} !== 2'b00) begin bad++; $display("FAIL popempty_flags: got %b want 00", {overflow, result_valid}); end
        f = rand_frame();
        drive(1'b1, f, 1'b1, 1'b0, 1'b0);
        total++; if (level !== LW'(1)) begin bad++; $display("FAIL pushpop_empty_level: got %0d want 1", level); end
        total++; if (result !== OW'(f)) begin bad++; $display("FAIL pushpop_empty_head: got %0h want %0h", result, f); end
    endtask

    task automatic test_sample();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < SPS; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
            total++; if (sample_count !== CW'((i + 1) % SPS)) begin bad++; $display("FAIL sample_count%0d: got %0d want %0d", i, sample_count, (i + 1) % SPS); end
            total++; if (step_done !== (i == SPS - 1)) begin bad++; $display("FAIL sample_step%0d: got %0b want %0b", i, step_done, i == SPS - 1); end
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        total++; if (step_done !== 1'b1) begin bad++; $display("FAIL step_sticky: got %0b want 1", step_done); end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        total++; if (step_done !== 1'b0) begin bad++; $display("FAIL step_clear: got %0b want 0", step_done); end
    endtask

    task automatic test_clear_priority();
        logic [DATA_WIDTH-1:0] f;
        drive(1'b1, rand_frame(), 1'b0, 1'b1, 1'b0);
        drive(1'b1, rand_frame(), 1'b0, 1'b1, 1'b0);
        drive(1'b1, rand_frame(), 1'b0, 1'b1, 1'b1);
        total++; if (level !== '0) begin bad++; $display("FAIL clear_level: got %0d want 0", level); end
        total++; if (sample_count !== '0) begin bad++; $display("FAIL clear_count: got %0d want 0", sample_count); end
        total++; if ({result_valid, overflow} !== 2'b00) begin bad++; $display("FAIL clear_valid: got %b want 00", {result_valid, overflow}); end
        total++; if (result !== '0) begin bad++; $display("FAIL clear_result: got %0h want 0", result); end
        f = rand_frame();
        drive(1'b1, f, 1'b0, 1'b0, 1'b0);
        total++; if (result !== OW'(f) || level !== LW'(1)) begin bad++; $display("FAIL clear_next_push: got %0d/%0h want 1/%0h", level, result, f); end
    endtask

    task automatic test_all_ones();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, '1, 1'b0, 1'b0, 1'b0);
        for (int w = 0; w < N_REG; w++) begin
            total++; if (result[w*WIDTH +: WIDTH] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ones_word%0d: got %0h want ffffffff", w, result[w*WIDTH +: WIDTH]); end
        end
        total++; if (result_b[25*WIDTH +: WIDTH] !== 32'h0) begin bad++; $display("FAIL ones_word25_nreg26: got %0h want 0", result_b[25*WIDTH +: WIDTH]); end
        total++; if (result_b[24*WIDTH +: WIDTH] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ones_word24_nreg26: got %0h want ffffffff", result_b[24*WIDTH +: WIDTH]); end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, rand_frame(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, rand_frame(), 1'b1, 1'b0, 1'b0);
            total++; if (result !== exp_head() || level !== LW'(sb.size())) begin bad++; $display("FAIL b2b%0d: got %0d/%0h want %0d/%0h", i, level, result, sb.size(), exp_head()); end
        end
    endtask

    task automatic test_random();
        logic v, p, s, c;
        for (int i = 0; i < 400; i++) begin
            v = 1'($urandom_range(0, 1));
            p = 1'($urandom_range(0, 2) == 0);
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 40) == 0);
            drive(v, rand_frame(), p, s, c);
            total++; if (result !== exp_head()) begin bad++; $display("FAIL rnd%0d_head: got %0h want %0h", i, result, exp_head()); end
            total++; if (level !== LW'(sb.size()) || result_valid !== (sb.size() != 0)) begin bad++; $display("FAIL rnd%0d_level: got %0d/%0b want %0d", i, level, result_valid, sb.size()); end
            total++; if (core_ready !== exp_ready()) begin bad++; $display("FAIL rnd%0d_ready: got %0b want %0b", i, core_ready, exp_ready()); end
            total++; if (sample_count !== CW'(m_cnt) || step_done !== m_step || overflow !== m_ovf) begin bad++; $display("FAIL rnd%0d_flags: got %0d/%0b/%0b want %0d/%0b/%0b", i, sample_count, step_done, overflow, m_cnt, m_step, m_ovf); end
        end
    endtask

    task automatic test_reset_midop();
        logic [DATA_WIDTH-1:0] f;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, rand_frame(), 1'b0, 1'b1, 1'b0);
        drive(1'b1, rand_frame(), 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++; if ({result_valid, level} !== '0) begin bad++; $display("FAIL midrst_level: got %0b/%0d want 0/0", result_valid, level); end
        total++; if (result !== '0 || sample_count !== '0) begin bad++; $display("FAIL midrst_state: got %0h/%0d want 0/0", result, sample_count); end
        total++; if (core_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %0b want 1", core_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        f = rand_frame();
        drive(1'b1, f, 1'b0, 1'b0, 1'b0);
        total++; if (result !== OW'(f) || level !== LW'(1)) begin bad++; $display("FAIL midrst_push: got %0d/%0h want 1/%0h", level, result, f); end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        core_data = '0; core_valid = 1'b0; sample = 1'b0; pop = 1'b0; clear = 1'b0;
        model_reset();
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_fifo_order();
        test_overflow();
        test_full_push_pop();
        test_pop_empty();
        test_sample();
        test_clear_priority();
        test_all_ones();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
